// File: rtl/eeprom_arbiter.sv
// eeprom_arbiter: shares a single-port EEPROM array between the I2C memory
// state machine (priority port) and the local host register port.
// Accesses are serialised through IDLE -> WRITE/READ -> ACK -> IDLE.
// The host is guaranteed a grant after MAX_SKIP consecutive contended losses.
// Optional feature: define MEM_ARB_WP_EN to suppress writes to addresses at or
// above WP_BASE and flag them with wp_err.
module eeprom_arbiter #(
    parameter int                ADDR_W     = 7,
    parameter int                DATA_W     = 8,
    parameter int                RD_LATENCY = 1,
    parameter int                MAX_SKIP   = 3,
    parameter logic [ADDR_W-1:0] WP_BASE    = 'h70
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i2c_req,
    input  logic              i2c_we,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic [DATA_W-1:0] i2c_wdata,
    output logic              i2c_ack,
    output logic [DATA_W-1:0] i2c_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wrdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rddata,

    output logic              busy,
    output logic              owner,
    output logic              wp_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam int              SKIP_W  = 4;
    localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(MAX_SKIP);
    // Down-counter start value: the READ state lasts RD_LATENCY cycles.
    localparam logic [1:0]      RD_LAST = 2'(RD_LATENCY - 1);

    state_t              state, state_nxt;
    logic [SKIP_W-1:0]   skip_cnt;
    logic [1:0]          rd_cnt;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;

    logic                any_req;
    logic                host_wins;
    logic                win_we;
    logic                wp_hit;

    // The array sees the latched access; these only change on a grant, so
    // they hold their last values outside WRITE and READ.
    assign mem_address = lat_addr;
    assign mem_wrdata  = lat_wdata;

`ifdef MEM_ARB_WP_EN
    assign wp_hit = lat_we && (lat_addr >= WP_BASE);
`else
    logic wp_base_unused;
    assign wp_hit         = 1'b0;
    assign wp_base_unused = ^WP_BASE;
`endif

    // Arbitration: I2C has priority unless the host has been skipped MAX_SKIP times.
    always_comb begin
        any_req   = i2c_req | host_req;
        host_wins = host_req && (!i2c_req || (skip_cnt == SKIP_MAX));
        win_we    = host_wins ? host_we : i2c_we;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // the pre-edge values; blocking here would create order-dependent races.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            IDLE:  if (any_req) state_nxt = win_we ? WRITE : READ;
            WRITE: state_nxt = ACK;
            READ:  if (rd_cnt == 2'd0) state_nxt = ACK;
            ACK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode from the current state and the latched access.
    always_comb begin
        busy     = (state != IDLE);
        mem_wren = 1'b0;
        i2c_ack  = 1'b0;
        host_ack = 1'b0;
        wp_err   = 1'b0;
        case (state)
            WRITE: mem_wren = lat_we && !wp_hit;
            ACK: begin
                i2c_ack  = !owner;
                host_ack = owner;
                wp_err   = wp_hit;
            end
            default: ;
        endcase
    end

    // Grant latching, fairness counter, read counter and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_cnt   <= '0;
            rd_cnt     <= '0;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            i2c_rdata  <= '0;
            host_rdata <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                owner     <= host_wins;
                lat_we    <= win_we;
                lat_addr  <= host_wins ? host_addr  : i2c_addr;
                lat_wdata <= host_wins ? host_wdata : i2c_wdata;
                rd_cnt    <= RD_LAST;
                if (host_wins) begin
                    skip_cnt <= '0;
                end else if (host_req && skip_cnt != SKIP_MAX) begin
                    // Host lost a contended grant; an uncontended I2C grant leaves it alone.
                    skip_cnt <= skip_cnt + 1'b1;
                end
            end
            if (state == READ) begin
                if (rd_cnt == 2'd0) begin
                    if (owner) host_rdata <= mem_rddata;
                    else       i2c_rdata  <= mem_rddata;
                end else begin
                    rd_cnt <= rd_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Directed testbench for eeprom_arbiter (RD_LATENCY = 2, MAX_SKIP = 3).
// Expected acks are queued as requests are driven and popped on each ack.
module tb_eeprom_arbiter;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

`ifdef MEM_ARB_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              i2c_req, i2c_we;
    logic [ADDR_W-1:0] i2c_addr;
    logic [DATA_W-1:0] i2c_wdata;
    logic              i2c_ack;
    logic [DATA_W-1:0] i2c_rdata;
    logic              host_req, host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wrdata;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_rddata;
    logic              busy, owner, wp_err;

    typedef struct {
        bit         port;   // 0 = I2C, 1 = host
        bit         we;
        logic [7:0] rdata;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_i2c_rdata  = 8'h00;
    logic [7:0] exp_host_rdata = 8'h00;

    eeprom_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(2), .MAX_SKIP(3), .WP_BASE(7'h70)
    ) dut (
        .clk(clk), .rst(rst),
        .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
        .i2c_ack(i2c_ack), .i2c_rdata(i2c_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_address(mem_address), .mem_wrdata(mem_wrdata), .mem_wren(mem_wren),
        .mem_rddata(mem_rddata),
        .busy(busy), .owner(owner), .wp_err(wp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; all driving and sampling happens on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ack(string tag);
        int n;
        n = 0;
        while (!(i2c_ack || host_ack) && n < 20) begin
            tick();
            n++;
        end
        if (!(i2c_ack || host_ack)) check({tag, "_ack_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pop_check(string tag);
        exp_t e;
        check({tag, "_sb_entry"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, "_owner"},    32'(owner),    32'(e.port));
        check({tag, "_i2c_ack"},  32'(i2c_ack),  32'(!e.port));
        check({tag, "_host_ack"}, 32'(host_ack), 32'(e.port));
        if (!e.we) begin
            if (e.port) exp_host_rdata = e.rdata;
            else        exp_i2c_rdata  = e.rdata;
        end
        check({tag, "_i2c_rdata"},  32'(i2c_rdata),  32'(exp_i2c_rdata));
        check({tag, "_host_rdata"}, 32'(host_rdata), 32'(exp_host_rdata));
    endtask

    initial begin
        bit exp_order [8];
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // ---- Reset with both ports requesting ----
        rst        = 1'b1;
        i2c_req    = 1'b1; i2c_we  = 1'b1; i2c_addr  = 7'h05; i2c_wdata  = 8'hA5;
        host_req   = 1'b1; host_we = 1'b0; host_addr = 7'h10; host_wdata = 8'h00;
        mem_rddata = 8'h9A;
        tick();
        tick();
        check("rst_i2c_ack",    32'(i2c_ack),     32'd0);
        check("rst_host_ack",   32'(host_ack),    32'd0);
        check("rst_mem_wren",   32'(mem_wren),    32'd0);
        check("rst_busy",       32'(busy),        32'd0);
        check("rst_owner",      32'(owner),       32'd0);
        check("rst_wp_err",     32'(wp_err),      32'd0);
        check("rst_i2c_rdata",  32'(i2c_rdata),   32'd0);
        check("rst_host_rdata", 32'(host_rdata),  32'd0);
        check("rst_mem_addr",   32'(mem_address), 32'd0);
        check("rst_mem_wrdata", 32'(mem_wrdata),  32'd0);

        // ---- Release: I2C write wins first, then host read (RD_LATENCY 2) ----
        rst = 1'b0;
        sb.push_back('{port: 1'b0, we: 1'b1, rdata: 8'h00});
        sb.push_back('{port: 1'b1, we: 1'b0, rdata: 8'h9A});
        tick();  // T+1: WRITE
        check("i2c_wr_wren",   32'(mem_wren),    32'd1);
        check("i2c_wr_addr",   32'(mem_address), 32'h05);
        check("i2c_wr_data",   32'(mem_wrdata),  32'hA5);
        check("i2c_wr_owner",  32'(owner),       32'd0);
        check("i2c_wr_busy",   32'(busy),        32'd1);
        check("i2c_wr_noack",  32'(i2c_ack),     32'd0);
        tick();  // T+2: ACK
        check("i2c_wr_wren_off", 32'(mem_wren), 32'd0);
        pop_check("i2c_wr");
        i2c_req = 1'b0;
        tick();  // IDLE
        check("idle_between_busy", 32'(busy), 32'd0);
        tick();  // T+1: READ
        check("host_rd_owner",  32'(owner),       32'd1);
        check("host_rd_addr1",  32'(mem_address), 32'h10);
        check("host_rd_wren",   32'(mem_wren),    32'd0);
        check("host_rd_noack1", 32'(host_ack),    32'd0);
        tick();  // T+2: READ
        check("host_rd_addr2",  32'(mem_address), 32'h10);
        check("host_rd_noack2", 32'(host_ack),    32'd0);
        check("host_rd_busy",   32'(busy),        32'd1);
        tick();  // T+3: ACK with data
        pop_check("host_rd");
        host_req = 1'b0;
        tick();  // IDLE

        // ---- Fairness: both ports re-request continuously ----
        i2c_req = 1'b1; i2c_we  = 1'b0; i2c_addr  = 7'h11;
        host_req = 1'b1; host_we = 1'b0; host_addr = 7'h22;
        for (int g = 0; g < 8; g++) begin
            mem_rddata = 8'h40 + 8'(g);
            sb.push_back('{port: exp_order[g], we: 1'b0, rdata: 8'h40 + 8'(g)});
            wait_ack($sformatf("fair%0d", g));
            pop_check($sformatf("fair%0d", g));
            if (owner) host_req = 1'b0;
            else       i2c_req  = 1'b0;
            tick();  // IDLE
            if (g == 7) begin
                i2c_req  = 1'b0;
                host_req = 1'b0;
            end else if (exp_order[g]) begin
                host_req = 1'b1;
            end else begin
                i2c_req = 1'b1;
            end
        end
        tick();

        // ---- Host write to a protected address ----
        host_req = 1'b1; host_we = 1'b1; host_addr = 7'h72; host_wdata = 8'h3C;
        sb.push_back('{port: 1'b1, we: 1'b1, rdata: 8'h00});
        tick();  // T+1: WRITE
        check("wp_wren",   32'(mem_wren),    32'(!WP_ON));
        check("wp_addr",   32'(mem_address), 32'h72);
        check("wp_wrdata", 32'(mem_wrdata),  32'h3C);
        check("wp_err_t1", 32'(wp_err),      32'd0);
        tick();  // T+2: ACK
        pop_check("wp");
        check("wp_err_t2", 32'(wp_err), 32'(WP_ON));
        host_req = 1'b0;
        tick();
        check("wp_err_idle", 32'(wp_err), 32'd0);

        // ---- Reset in the middle of a read ----
        i2c_req = 1'b1; i2c_we = 1'b0; i2c_addr = 7'h20;
        mem_rddata = 8'h77;
        tick();  // READ
        check("mid_rd_busy", 32'(busy), 32'd1);
        rst     = 1'b1;
        i2c_req = 1'b0;
        tick();
        check("mid_rst_busy",     32'(busy),        32'd0);
        check("mid_rst_i2c_ack",  32'(i2c_ack),     32'd0);
        check("mid_rst_host_ack", 32'(host_ack),    32'd0);
        check("mid_rst_wren",     32'(mem_wren),    32'd0);
        check("mid_rst_addr",     32'(mem_address), 32'd0);
        check("mid_rst_i2c_rd",   32'(i2c_rdata),   32'd0);
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_i2c_ack",  32'(i2c_ack),  32'd0);
        check("post_rst_host_ack", 32'(host_ack), 32'd0);
        check("post_rst_busy",     32'(busy),     32'd0);
        check("sb_drained",        32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/eeprom_arbiter.md
# eeprom_arbiter

Shares the single-port 128×8 EEPROM array between two requesters: the I2C-side memory state machine (priority port) and a local host register port. It serialises accesses, drives the array's address, write-data and write-enable, and returns read data and completion handshakes. It sits between both requesters and the array, replacing their direct wiring. Host fairness is guaranteed by a bounded-skip counter.

## Interface
- `ADDR_W`, 7: array address width.
- `DATA_W`, 8: array data width.
- `RD_LATENCY`, 1: array read latency in cycles (legal 1–2).
- `MAX_SKIP`, 3: consecutive host losses before the host is forced a grant (legal 1–15).
- `WP_BASE`, 7'h70: lowest write-protected address (used only with `MEM_ARB_WP_EN`).

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i2c_req` in 1: I2C access request, level, held until `i2c_ack`.
- `i2c_we` in 1: 1 = write, 0 = read; stable while `i2c_req` is high.
- `i2c_addr` in ADDR_W: I2C access address.
- `i2c_wdata` in DATA_W: I2C write data.
- `i2c_ack` out 1: one-cycle completion pulse.
- `i2c_rdata` out DATA_W: last I2C read result, held.
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_ack`, `host_rdata`: same definitions as the I2C port.
- `mem_address` out ADDR_W: array address.
- `mem_wrdata` out DATA_W: array write data.
- `mem_wren` out 1: array write enable.
- `mem_rddata` in DATA_W: array read data.
- `busy` out 1: high in any state other than IDLE.
- `owner` out 1: current or last grantee (0 = I2C, 1 = host).
- `wp_err` out 1: one-cycle pulse, coincident with the ack of a suppressed write.

## Operation
- States: IDLE, WRITE, READ, ACK.
- Requests are sampled only in IDLE.
- **Grant on a sampled request**
  - Latch the winning port's `we`, `addr` and `wdata`.
  - Set `owner` to the winner.
  - Go to WRITE if `we` = 1, otherwise to READ.
- **Arbitration when both ports request**
  - If `skip_cnt` == `MAX_SKIP`, the host wins and `skip_cnt` clears to 0.
  - Otherwise I2C wins and `skip_cnt` increments (saturating at `MAX_SKIP`).
- **Arbitration when only one port requests**
  - That port wins.
  - A host grant clears `skip_cnt`.
  - An I2C grant with no host request leaves `skip_cnt` unchanged.
- **WRITE** (exactly 1 cycle)
  - `mem_address` = latched address, `mem_wrdata` = latched data, `mem_wren` = 1.
  - Next state is ACK.
- **READ** (`RD_LATENCY` cycles, tracked by a down-counter)
  - `mem_address` is held at the latched address.
  - On the last READ cycle, `mem_rddata` is captured into the owner's `*_rdata` register.
  - Next state is ACK.
- **ACK** (1 cycle)
  - The owner's `*_ack` = 1.
  - Next state is IDLE.
- A requester must deassert `req` in the cycle after its ack. A `req` still high in IDLE is treated as a new request.
- `mem_address` and `mem_wrdata` hold their last values outside WRITE and READ.
- `mem_wren` is 0 in every state except WRITE.
- The non-owner's `*_rdata` is never modified.
- **Reset** (from any state, including mid-WRITE or mid-READ)
  - State becomes IDLE at the next edge; the pending access is dropped and no ack is issued.
  - All outputs, `skip_cnt` and the latched registers become 0.

## Timing
- Request sampled high in IDLE at cycle T.
- Write: `mem_wren` high at T+1 only; ack at T+2; IDLE at T+3.
- Read: address valid T+1 through T+`RD_LATENCY`; `rdata` updated and ack at T+`RD_LATENCY`+1; IDLE one cycle later.
- Back-to-back accesses by one port: minimum 3 cycles per write and `RD_LATENCY`+2 per read, because IDLE is always visited between accesses.
- Reset values: `i2c_ack`, `host_ack`, `mem_wren`, `busy`, `owner`, `wp_err` = 0; `i2c_rdata`, `host_rdata`, `mem_address`, `mem_wrdata` = 0.

## Configuration
- `MEM_ARB_WP_EN` defined:
  - A write to an address ≥ `WP_BASE` still passes through WRITE, but `mem_wren` stays 0.
  - The ack is issued normally, and `wp_err` pulses in the ACK cycle.
- `MEM_ARB_WP_EN` undefined:
  - All writes assert `mem_wren`.
  - `wp_err` is tied to 0, and `WP_BASE` is ignored.

## Test plan
- **Reset:** assert `rst` for 2 cycles with both requests high → all outputs 0. After release, I2C is granted first.
- **I2C write:** `i2c_req`, we=1, addr 7'h05, data 8'hA5 → `mem_wren`=1 with addr 05 / data A5 at T+1 only; `i2c_ack` at T+2; `owner`=0.
- **Host read:** `RD_LATENCY`=2, addr 7'h10, `mem_rddata`=8'h9A → address 10 held at T+1–T+2; `host_rdata`=9A and `host_ack` at T+3; `i2c_rdata` unchanged.
- **Fairness under contention:** `MAX_SKIP`=3, both ports re-requesting continuously → grant order I,I,I,H,I,I,I,H.
- **Write protect:** host write to 7'h72 → with the macro, `mem_wren` stays 0 and `host_ack` and `wp_err` pulse together at T+2. Without the macro, `mem_wren`=1 at T+1 and `wp_err` stays 0.
- **Reset mid-read:** `rst` asserted during READ → IDLE next cycle, no ack, `mem_wren` 0, `busy` 0.
